// File: rtl/heap_fetch_arbiter.sv
// Two-port heap read arbiter: round-robin grant, fixed-latency wait, node decode, held response.
// Optional grant/error statistics outputs are enabled with the HEAP_FETCH_STATS_EN macro.
module heap_fetch_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int STAT_W  = 16
) (
    input  logic        system1000,
    input  logic        system1000_rstn,
    input  logic        req0_valid,
    input  logic [29:0] req0_addr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [29:0] req1_addr,
    output logic        req1_ready,
    output logic        mem_rd_en,
    output logic [29:0] mem_addr,
    input  logic [63:0] mem_rd_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [62:0] resp_node,
    output logic        resp_err
`ifdef HEAP_FETCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_fetch0,
    output logic [STAT_W-1:0] stat_fetch1,
    output logic [STAT_W-1:0] stat_err
`endif
);

    if (MEM_LAT < 1 || MEM_LAT > 7 || STAT_W < 1) begin : g_param_check
        $error("heap_fetch_arbiter: MEM_LAT must be 1..7 and STAT_W >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic        rr_q, rr_d;
    logic        id_q, id_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;
    logic [62:0] resp_node_q, resp_node_d;
    logic        resp_err_q, resp_err_d;
    logic        gnt_s;
    logic        gnt_port_s;
    logic [63:0] dec_s;

    // Result is {err, node}; unknown tags yield an all-zero node with err set.
    function automatic logic [63:0] decode_word(input logic [63:0] w);
        logic [63:0] r;
        r = 64'd0;
        case (w[63:60])
            4'd0:    r = {1'b0, 3'b000, 60'd0};
            4'd1:    r = {1'b0, 3'b001, 60'd0};
            4'd2:    r = {1'b0, 3'b010, 60'd0};
            4'd3:    r = {1'b0, 3'b011, w[59:30], w[29:0]};
            4'd4:    r = {1'b0, 3'b100, w[31:0], 28'd0};
            default: r = {1'b1, 63'd0};
        endcase
        return r;
    endfunction

    assign dec_s = decode_word(mem_rd_data);

    // Grant selection: only in IDLE and never while reset is asserted.
    always_comb begin
        gnt_s      = 1'b0;
        gnt_port_s = 1'b0;
        if (system1000_rstn && (state_q == ST_IDLE)) begin
            if (req0_valid && req1_valid) begin
                gnt_s      = 1'b1;
                gnt_port_s = ~rr_q;
            end else if (req0_valid) begin
                gnt_s      = 1'b1;
                gnt_port_s = 1'b0;
            end else if (req1_valid) begin
                gnt_s      = 1'b1;
                gnt_port_s = 1'b1;
            end else begin
                gnt_s      = 1'b0;
                gnt_port_s = 1'b0;
            end
        end else begin
            gnt_s      = 1'b0;
            gnt_port_s = 1'b0;
        end
    end

    assign req0_ready = gnt_s & ~gnt_port_s;
    assign req1_ready = gnt_s & gnt_port_s;
    assign mem_rd_en  = gnt_s;
    assign mem_addr   = gnt_s ? (gnt_port_s ? req1_addr : req0_addr) : 30'd0;

    // Next-state logic for the fetch sequencer.
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        rr_d         = rr_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_node_d  = resp_node_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_s) begin
                    id_d    = gnt_port_s;
                    rr_d    = gnt_port_s;
                    lat_d   = 3'(MEM_LAT - 1);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_q == 3'd0) begin
                    resp_err_d   = dec_s[63];
                    resp_node_d  = dec_s[62:0];
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            ST_HOLD: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            state_q      <= ST_IDLE;
            lat_q        <= 3'd0;
            rr_q         <= 1'b1;
            id_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_node_q  <= 63'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            rr_q         <= rr_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_node_q  <= resp_node_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_node  = resp_node_q;
    assign resp_err   = resp_err_q;

`ifdef HEAP_FETCH_STATS_EN
    logic [STAT_W-1:0] stat_fetch0_q, stat_fetch1_q, stat_err_q;
    logic              hold_entry_err_s;

    assign hold_entry_err_s = (state_q == ST_WAIT) && (lat_q == 3'd0) && dec_s[63];

    // Saturating statistics counters.
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            stat_fetch0_q <= '0;
            stat_fetch1_q <= '0;
            stat_err_q    <= '0;
        end else begin
            if (req0_ready && (stat_fetch0_q != '1)) begin
                stat_fetch0_q <= stat_fetch0_q + STAT_W'(1);
            end
            if (req1_ready && (stat_fetch1_q != '1)) begin
                stat_fetch1_q <= stat_fetch1_q + STAT_W'(1);
            end
            if (hold_entry_err_s && (stat_err_q != '1)) begin
                stat_err_q <= stat_err_q + STAT_W'(1);
            end
        end
    end

    assign stat_fetch0 = stat_fetch0_q;
    assign stat_fetch1 = stat_fetch1_q;
    assign stat_err    = stat_err_q;
`endif

endmodule
